// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, IR handoff to the sequencer,
// redirect input from execute and halt status.
interface fetch_unit_if #(
    parameter int PC_WIDTH   = 8,
    parameter int INSN_WIDTH = 16
);
    logic [PC_WIDTH-1:0]   pc;
    logic [INSN_WIDTH-1:0] instruction;
    logic [INSN_WIDTH-1:0] ir;
    logic [PC_WIDTH-1:0]   ir_pc;
    logic                  ir_valid;
    logic                  ir_ready;
    logic                  redirect;
    logic [PC_WIDTH-1:0]   redirect_target;
    logic                  halted;

    modport master (
        output pc, ir, ir_pc, ir_valid, halted,
        input  instruction, ir_ready, redirect, redirect_target
    );

    modport slave (
        input  pc, ir, ir_pc, ir_valid, halted,
        output instruction, ir_ready, redirect, redirect_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC, one-entry IR with valid/ready handoff, redirect, halt.
// Optional FETCH_JMP_FOLD_EN folds jmp words (upper byte 8'h03) in fetch.
module fetch_unit #(
    parameter int                     PC_WIDTH     = 8,
    parameter int                     INSN_WIDTH   = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = 8'h00,
    parameter logic [INSN_WIDTH-1:0]  HALT_WORD    = 16'hffff
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {
        FETCH,
        HALT_PEND,
        HALTED
    } state_t;

    state_t                state, state_n;
    logic [PC_WIDTH-1:0]   pc_q, pc_n;
    logic [INSN_WIDTH-1:0] ir_q, ir_n;
    logic [PC_WIDTH-1:0]   ir_pc_q, ir_pc_n;
    logic                  valid_q, valid_n;
    logic                  halted_q, halted_n;

    logic transfer;
    logic ir_free;
    logic is_halt;
    logic fold;

    assign transfer = valid_q && bus.ir_ready;
    assign ir_free  = !valid_q || transfer;
    assign is_halt  = (bus.instruction == HALT_WORD);

`ifdef FETCH_JMP_FOLD_EN
    assign fold = (bus.instruction[INSN_WIDTH-1 -: 8] == 8'h03);
`else
    assign fold = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            pc_q     <= RESET_VECTOR;
            ir_q     <= '0;
            ir_pc_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state    <= state_n;
            pc_q     <= pc_n;
            ir_q     <= ir_n;
            ir_pc_q  <= ir_pc_n;
            valid_q  <= valid_n;
            halted_q <= halted_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc_q;
        ir_n     = ir_q;
        ir_pc_n  = ir_pc_q;
        valid_n  = valid_q;
        halted_n = halted_q;
        unique case (state)
            FETCH: begin
                if (bus.redirect) begin
                    valid_n = 1'b0;
                    pc_n    = bus.redirect_target;
                end else if (ir_free) begin
                    if (fold) begin
                        // jmp retires in fetch; IR only drains
                        valid_n = 1'b0;
                        pc_n    = bus.instruction[PC_WIDTH-1:0];
                    end else begin
                        ir_n    = bus.instruction;
                        ir_pc_n = pc_q;
                        valid_n = 1'b1;
                        if (is_halt) begin
                            state_n = HALT_PEND;
                        end else begin
                            pc_n = pc_q + PC_WIDTH'(1);
                        end
                    end
                end
            end
            HALT_PEND: begin
                if (bus.redirect) begin
                    valid_n = 1'b0;
                    pc_n    = bus.redirect_target;
                    state_n = FETCH;
                end else if (transfer) begin
                    valid_n  = 1'b0;
                    halted_n = 1'b1;
                    state_n  = HALTED;
                end
            end
            HALTED: begin
                valid_n  = 1'b0;
                halted_n = 1'b1;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    assign bus.pc       = pc_q;
    assign bus.ir       = ir_q;
    assign bus.ir_pc    = ir_pc_q;
    assign bus.ir_valid = valid_q;
    assign bus.halted   = halted_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus hand-written
// sequences for halt flush, redirect/halt collision, wrap and reset.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] rom [256];

    fetch_unit_if #(.PC_WIDTH(8), .INSN_WIDTH(16)) bus();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.instruction = rom[bus.pc];

    typedef struct packed {
        logic        rdy;
        logic        redir;
        logic [7:0]  tgt;
        logic [7:0]  pc;
        logic [15:0] ir;
        logic [7:0]  ir_pc;
        logic        v;
        logic        h;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [7:0] epc,
                         input logic [15:0] eir, input logic [7:0] eirpc,
                         input logic ev, input logic eh);
        logic [33:0] act, exp;
        act = {bus.pc, bus.ir, bus.ir_pc, bus.ir_valid, bus.halted};
        exp = {epc, eir, eirpc, ev, eh};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got pc=%h ir=%h ir_pc=%h v=%b h=%b, want pc=%h ir=%h ir_pc=%h v=%b h=%b",
                     name, bus.pc, bus.ir, bus.ir_pc, bus.ir_valid, bus.halted,
                     epc, eir, eirpc, ev, eh);
        end
    endtask

    task automatic step(input logic rdy, input logic redir, input logic [7:0] tgt);
        bus.ir_ready        = rdy;
        bus.redirect        = redir;
        bus.redirect_target = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.ir_ready        = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = 8'h00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 16'h1000 | 16'(a);
        rom[8'h00] = 16'h7f00;
        rom[8'h01] = 16'h0100;
        rom[8'h02] = 16'h0101;
        rom[8'h0d] = 16'hffff;
`ifdef FETCH_JMP_FOLD_EN
        rom[8'h0b] = 16'h0303;
`endif

        //           rdy   rd    tgt    pc     ir        ir_pc  v     h
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 8'h01, 16'h7f00, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 8'h02, 16'h0100, 8'h01, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 8'h02, 16'h0100, 8'h01, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 8'h02, 16'h0100, 8'h01, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'h02, 16'h0100, 8'h01, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 8'h03, 16'h0101, 8'h02, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 8'h04, 16'h1003, 8'h03, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 8'h05, 16'h1004, 8'h04, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 8'h06, 16'h1005, 8'h05, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 8'h0c, 8'h0c, 16'h1005, 8'h05, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 8'h0d, 16'h100c, 8'h0c, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 8'h0d, 16'hffff, 8'h0d, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 8'h0d, 16'hffff, 8'h0d, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 8'h0d, 16'hffff, 8'h0d, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 8'h00, 8'h0d, 16'hffff, 8'h0d, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 8'h00, 8'h0d, 16'hffff, 8'h0d, 1'b0, 1'b1};

        do_reset();
        check("reset", 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rdy, vecs[i].redir, vecs[i].tgt);
            check($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ir,
                  vecs[i].ir_pc, vecs[i].v, vecs[i].h);
        end

        // reset out of the halted state, between edges
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_async", 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0);

        // redirect collides with the halt fetch: halt word never latched
        do_reset();
        step(1'b1, 1'b1, 8'h0c);
        check("coll_redir", 8'h0c, 16'h0000, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00);
        check("coll_fetch", 8'h0d, 16'h100c, 8'h0c, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h05);
        check("coll_win", 8'h05, 16'h100c, 8'h0c, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00);
        check("coll_resume", 8'h06, 16'h1005, 8'h05, 1'b1, 1'b0);

        // redirect while halt is pending flushes it
        do_reset();
        step(1'b1, 1'b1, 8'h0d);
        step(1'b0, 1'b0, 8'h00);
        check("hp_enter", 8'h0d, 16'hffff, 8'h0d, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'h20);
        check("hp_flush", 8'h20, 16'hffff, 8'h0d, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00);
        check("hp_resume", 8'h21, 16'h1020, 8'h20, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00);
        check("hp_stream", 8'h22, 16'h1021, 8'h21, 1'b1, 1'b0);

        // PC wrap at 8'hff
        do_reset();
        step(1'b1, 1'b1, 8'hff);
        check("wrap_redir", 8'hff, 16'h0000, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00);
        check("wrap_fetch", 8'h00, 16'h10ff, 8'hff, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00);
        check("wrap_next", 8'h01, 16'h7f00, 8'h00, 1'b1, 1'b0);

        // mid-stream async reset
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid", 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0);

`ifdef FETCH_JMP_FOLD_EN
        do_reset();
        step(1'b1, 1'b1, 8'h0a);
        step(1'b1, 1'b0, 8'h00);
        check("fold_pre", 8'h0b, 16'h100a, 8'h0a, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00);
        check("fold_jmp", 8'h03, 16'h100a, 8'h0a, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00);
        check("fold_tgt", 8'h04, 16'h1003, 8'h03, 1'b1, 1'b0);
`endif

        rst = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the microcoded accumulator CPU.
- Owns the program counter and drives the combinational program ROM address.
- Captures the returned instruction word into a one-entry instruction register (IR) and hands it to the microcode sequencer through a valid/ready handshake.
- Accepts control-flow redirects from execute and stops fetching after delivering a halt word.

Parameters:
- PC_WIDTH, 8, width of program counter and ROM address.
- INSN_WIDTH, 16, width of instruction word.
- RESET_VECTOR, 8'h00, PC value loaded on reset.
- HALT_WORD, 16'hffff, encoding that stops fetch.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc  output  PC_WIDTH  ROM address; registered PC, drives ROM directly.
- instruction  input  INSN_WIDTH  ROM data for the current pc; combinational, same cycle.
- ir  output  INSN_WIDTH  latched instruction for the sequencer.
- ir_pc  output  PC_WIDTH  address the word in ir was fetched from.
- ir_valid  output  1  ir holds an undelivered instruction.
- ir_ready  input  1  sequencer accepts ir this cycle.
- redirect  input  1  execute requests a PC change (taken jz/jmp).
- redirect_target  input  PC_WIDTH  new PC value.
- halted  output  1  halt word consumed; fetch stopped.

Behaviour:
- Reset (async, any state): pc=RESET_VECTOR, ir=0, ir_pc=0, ir_valid=0, halted=0, state=FETCH.
- Transfer definition: a transfer occurs when ir_valid && ir_ready.
- IR "free" definition: the IR is free when !ir_valid or a transfer occurs this cycle.
- States:
  - FETCH: normal streaming.
  - HALT_PEND: halt word is in IR, awaiting transfer; no further fetch.
  - HALTED: terminal; sticky until rst.
- FETCH, IR free, no redirect:
  - ir<=instruction, ir_pc<=pc, ir_valid<=1, pc<=pc+1.
  - PC wraps modulo 2^PC_WIDTH (8'hff -> 8'h00).
  - If instruction==HALT_WORD: pc holds (no increment), next state HALT_PEND.
- FETCH, IR not free: ir, ir_pc, and pc all hold.
- Sustained throughput: one instruction per cycle while ir_ready stays high.
- Latency: ROM word at pc appears on ir with ir_valid=1 at the next rising edge.
  - The first instruction is valid one edge after rst deasserts.
- Redirect (highest priority, FETCH or HALT_PEND):
  - ir_valid<=0, pc<=redirect_target, state<=FETCH.
  - The word on instruction that cycle is discarded.
  - The sequencer's transfer in the same cycle still completes; the redirect originates from that word.
  - Execution resumes at the target with the one-cycle fetch latency.
- HALT_PEND:
  - On transfer: ir_valid<=0, halted<=1, state<=HALTED.
  - Otherwise hold.
- HALTED:
  - redirect and ir_ready are ignored; pc, ir, and ir_pc hold; ir_valid=0, halted=1.
- Simultaneous events:
  - Redirect and halt fetch in the same cycle: redirect wins; the halt word is never latched.
  - Redirect in HALT_PEND: the halt word is flushed and halted stays 0.
- All outputs are registered; no combinational path from ir_ready or redirect to any output.

Optional Feature:
- Macro FETCH_JMP_FOLD_EN.
- When defined, in FETCH with IR free and no redirect, a word whose upper byte is 8'h03 (jmp) is folded:
  - pc<=instruction[PC_WIDTH-1:0].
  - ir and ir_valid are not updated, so the jmp is never presented to the sequencer.
  - A jmp-to-self loops in fetch indefinitely with ir_valid=0 after the prior word drains.
- When undefined, jmp words pass through like any other instruction.

Test Plan:
- Reset, ir_ready=1, ROM words 7f00,0100,0101 at 0..2:
  - ir_valid rises at the first edge with ir=16'h7f00, ir_pc=0.
  - Following edges give ir=16'h0100 then 16'h0101.
  - pc=8'h03 after three edges.
- Backpressure: hold ir_ready=0 for 3 cycles with ir=16'h0100, ir_pc=1 → ir, ir_pc, and pc=8'h02 are all stable; on ir_ready=1 the stream resumes with 16'h0101.
- Redirect: assert redirect with redirect_target=8'h0c while ir_pc=5 → next edge gives ir_valid=0 and pc=8'h0c; the following edge gives ir_pc=8'h0c.
- Halt: ROM address 0x0d returns 16'hffff:
  - ir=16'hffff, pc stays 8'h0d, state HALT_PEND.
  - After transfer: halted=1, ir_valid=0.
  - A later redirect to 8'h00 leaves pc=8'h0d.
- Wrap and reset: force redirect_target=8'hff with a non-halt word at 0xff → pc becomes 8'h00 after the fetch. Asserting rst mid-stream immediately gives pc=0, ir_valid=0, halted=0.
- FETCH_JMP_FOLD_EN build: word 16'h0303 at 0x0b:
  - Next pc=8'h03.
  - The ir_pc sequence skips 0x0b (…,0x0a,0x03,…).
